// File: rtl/result_tx_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : result_tx_packer_if
// Description : Bundle of the result-strobe input, the valid/ready byte
//               stream towards the host link and the packer status outputs.
//               master = result source / byte sink side,
//               slave  = result_tx_packer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface result_tx_packer_if;
  logic       done_signal;   // result strobe
  logic [7:0] result_data;   // result byte, valid with done_signal
  logic [7:0] confidence;    // confidence byte, valid with done_signal
  logic [7:0] tx_byte;       // outgoing stream byte
  logic       tx_valid;      // tx_byte valid
  logic       tx_ready;      // sink accepts on tx_valid && tx_ready
  logic       busy;          // queue non-empty or frame in progress
  logic       overflow;      // sticky result-drop flag
  logic [7:0] frame_count;   // completed frames, wraps at 256

  modport master (
    output done_signal, result_data, confidence, tx_ready,
    input  tx_byte, tx_valid, busy, overflow, frame_count
  );

  modport slave (
    input  done_signal, result_data, confidence, tx_ready,
    output tx_byte, tx_valid, busy, overflow, frame_count
  );
endinterface
`default_nettype wire

// File: rtl/result_tx_packer.sv
`default_nettype none
// ============================================================================
// Module      : result_tx_packer
// Description : Queues {result, confidence} pairs strobed by done_signal and
//               serialises each as a 4-byte frame (sync, result, confidence,
//               checksum) on a valid/ready byte stream.
// Ports       : clk  - single rising-edge clock
//               rst  - asynchronous active-high reset
//               bus  - result_tx_packer_if.slave (strobe inputs, tx stream,
//                      busy / overflow / frame_count status)
// Revision    : 1.0 - initial release
// ============================================================================
module result_tx_packer #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         FIFO_DEPTH = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  result_tx_packer_if.slave      bus
);

  localparam int c_AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] c_S_IDLE = 3'd0;
  localparam logic [2:0] c_S_SYNC = 3'd1;
  localparam logic [2:0] c_S_RES  = 3'd2;
  localparam logic [2:0] c_S_CONF = 3'd3;
  localparam logic [2:0] c_S_CSUM = 3'd4;

  // Queue storage; pointers carry one extra wrap bit to separate full/empty
  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [c_AW:0] r_wr_ptr;
  logic [c_AW:0] r_rd_ptr;

  logic [2:0]    r_state;
  logic [7:0]    r_hold_res;
  logic [7:0]    r_hold_conf;
  logic [7:0]    r_tx_byte;
  logic          r_tx_valid;
  logic          r_busy;
  logic          r_overflow;
  logic [7:0]    r_frame_count;

  logic          w_empty;
  logic          w_full;
  logic          w_accept;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [15:0]   w_head;
  logic [c_AW:0] w_wr_nxt;
  logic [c_AW:0] w_rd_nxt;
  logic [7:0]    w_csum;
  logic [2:0]    w_state_nxt;
  logic [7:0]    w_tx_byte_nxt;
  logic          w_tx_valid_nxt;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                    (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_accept = r_tx_valid && bus.tx_ready;

  // An entry leaves the queue when the FSM (re)starts a frame
  assign w_pop    = !w_empty &&
                    ((r_state == c_S_IDLE) || ((r_state == c_S_CSUM) && w_accept));
  // A full queue still accepts a push when a pop frees a slot on the same edge
  assign w_push   = bus.done_signal && (!w_full || w_pop);
  assign w_drop   = bus.done_signal && w_full && !w_pop;

  assign w_head   = r_mem[r_rd_ptr[c_AW-1:0]];
  assign w_wr_nxt = r_wr_ptr + (c_AW+1)'(w_push);
  assign w_rd_nxt = r_rd_ptr + (c_AW+1)'(w_pop);
  assign w_csum   = SYNC_BYTE + r_hold_res + r_hold_conf;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: if (!w_empty) w_state_nxt = c_S_SYNC;
      c_S_SYNC: if (w_accept) w_state_nxt = c_S_RES;
      c_S_RES:  if (w_accept) w_state_nxt = c_S_CONF;
      c_S_CONF: if (w_accept) w_state_nxt = c_S_CSUM;
      c_S_CSUM: if (w_accept) w_state_nxt = w_empty ? c_S_IDLE : c_S_SYNC;
      default:  w_state_nxt = c_S_IDLE;
    endcase
  end

  // ---------------- FSM: output logic ----------------
  // Outputs are decoded from the next state and registered alongside it, so
  // tx_byte/tx_valid line up with the state register and stay stable while
  // the state holds waiting for tx_ready. Holding registers only change on a
  // pop, which always lands in SYNC where the byte is the constant sync value.
  always_comb begin
    w_tx_valid_nxt = (w_state_nxt != c_S_IDLE);
    w_tx_byte_nxt  = 8'h00;
    case (w_state_nxt)
      c_S_SYNC: w_tx_byte_nxt = SYNC_BYTE;
      c_S_RES:  w_tx_byte_nxt = r_hold_res;
      c_S_CONF: w_tx_byte_nxt = r_hold_conf;
      c_S_CSUM: w_tx_byte_nxt = w_csum;
      default:  w_tx_byte_nxt = 8'h00;
    endcase
  end

  // Queue storage is not reset; the pointers define its contents
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= {bus.result_data, bus.confidence};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_hold_res    <= 8'h00;
      r_hold_conf   <= 8'h00;
      r_tx_byte     <= 8'h00;
      r_tx_valid    <= 1'b0;
      r_busy        <= 1'b0;
      r_overflow    <= 1'b0;
      r_frame_count <= 8'h00;
    end else begin
      r_wr_ptr   <= w_wr_nxt;
      r_rd_ptr   <= w_rd_nxt;
      if (w_pop) begin
        r_hold_res  <= w_head[15:8];
        r_hold_conf <= w_head[7:0];
      end
      r_tx_byte  <= w_tx_byte_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_busy     <= (w_state_nxt != c_S_IDLE) || (w_wr_nxt != w_rd_nxt);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if ((r_state == c_S_CSUM) && w_accept) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign bus.tx_byte     = r_tx_byte;
  assign bus.tx_valid    = r_tx_valid;
  assign bus.busy        = r_busy;
  assign bus.overflow    = r_overflow;
  assign bus.frame_count = r_frame_count;

endmodule
`default_nettype wire
